collector_tx_packetizer: RTL and testbench

- Upstream feeder for the active_transfer byte channel on the data-collector CPLD.
- Captures bytes strobed in from the Arduino local bus (strobe plus data byte) and buffers them in a 16-deep FIFO.
- While collection is enabled, emits framed packets one byte at a time as start_transfer pulses with a paced byte bus.
- Packet format: SOF, sequence, length, payload, checksum.

---
 rtl/collector_pkg.sv | 22 ++
 rtl/collector_sync_fifo.sv | 58 +++++
 rtl/collector_tx_packetizer.sv | 146 ++++++++++++++
 tb/tb_collector_tx_packetizer.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/collector_pkg.sv
// Shared definitions for the collector transmit path: FSM encoding,
// default start-of-frame marker and packet field offsets.
package collector_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SEND_SOF  = 3'd1,
    SEND_SEQ  = 3'd2,
    SEND_LEN  = 3'd3,
    SEND_DATA = 3'd4,
    SEND_CSUM = 3'd5
  } state_e;

  localparam logic [7:0] SOF_BYTE_DEFAULT = 8'hA5;

  // Byte offsets of the header fields within a packet
  localparam int FIELD_SOF  = 0;
  localparam int FIELD_SEQ  = 1;
  localparam int FIELD_LEN  = 2;
  localparam int FIELD_DATA = 3;

endpackage

// File: rtl/collector_sync_fifo.sv
// Circular byte FIFO with push/pop/flush; occupancy is the pointer
// difference, pointers carry one extra wrap bit.
module collector_sync_fifo
  import collector_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                     CLK_66,
  input  logic                     RST,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wr_data,
  output logic [WIDTH-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr_reg;
  logic [AW:0]      rd_ptr_reg;
  logic             do_push;
  logic             do_pop;

  assign count = wr_ptr_reg - rd_ptr_reg;
  assign full  = (count == DEPTH_CNT);
  assign empty = (count == '0);

  // A pop in the same cycle frees the slot, so a full FIFO still accepts
  assign do_pop  = pop & ~empty & ~flush;
  assign do_push = push & (~full | do_pop) & ~flush;

  always_ff @(posedge CLK_66 or negedge RST) begin
    if (!RST) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
    end
  end

  always_ff @(posedge CLK_66) begin
    if (do_push) mem[wr_ptr_reg[AW-1:0]] <= wr_data;
  end

  // Head is read combinationally so the popped byte is valid in its pulse cycle
  assign rd_data = mem[rd_ptr_reg[AW-1:0]];

endmodule

// File: rtl/collector_tx_packetizer.sv
// Captures strobed Arduino bytes into a FIFO and emits paced framed packets:
// SOF, sequence, length, payload, checksum.
module collector_tx_packetizer
  import collector_pkg::*;
#(
  parameter int         FIFO_DEPTH    = 16,
  parameter int         PAYLOAD_LEN   = 4,
  parameter logic [7:0] SOF_BYTE      = SOF_BYTE_DEFAULT,
  parameter int         TX_GAP_CYCLES = 8
) (
  input  logic                          CLK_66,
  input  logic                          RST,
  input  logic                          enable,
  input  logic                          flush,
  input  logic                          wr_strobe_async,
  input  logic [7:0]                    wr_data,
  output logic                          start_transfer,
  output logic [7:0]                    transfer_to_host,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow,
  output logic                          busy
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int GW = $clog2(TX_GAP_CYCLES);
  localparam logic [GW-1:0] GAP_LAST = GW'(TX_GAP_CYCLES - 1);
  localparam logic [CW-1:0] IDX_LAST = CW'(PAYLOAD_LEN - 1);
  localparam logic [CW-1:0] LEN_CNT  = CW'(PAYLOAD_LEN);
  localparam logic [7:0]    LEN_BYTE = 8'(PAYLOAD_LEN);

  logic [2:0]    strobe_sync_reg;
  logic          capture_edge;
  logic          push_reg;
  logic [7:0]    push_data_reg;
  logic [7:0]    head_byte;
  logic          fifo_full;
  logic          fifo_empty;
  logic          pop;
  state_e        state_reg, state_next;
  logic [GW-1:0] gap_reg;
  logic [CW-1:0] idx_reg;
  logic [7:0]    seq_reg;
  logic [7:0]    csum_reg;
  logic [7:0]    tx_hold_reg;
  logic          overflow_reg;
  logic [7:0]    cur_byte;
  logic          gap_last;

  // Bits [1:0] synchronise the strobe, bit [2] is the previous value for edge detect
  assign capture_edge = strobe_sync_reg[1] & ~strobe_sync_reg[2];
  assign gap_last     = (gap_reg == GAP_LAST);

  always_ff @(posedge CLK_66 or negedge RST) begin
    if (!RST) begin
      strobe_sync_reg <= '0;
      push_reg        <= 1'b0;
      push_data_reg   <= '0;
    end else begin
      strobe_sync_reg <= {strobe_sync_reg[1:0], wr_strobe_async};
      push_reg        <= capture_edge & ~flush;
      if (capture_edge) push_data_reg <= wr_data;
    end
  end

  collector_sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .CLK_66  (CLK_66),
    .RST     (RST),
    .flush   (flush),
    .push    (push_reg),
    .pop     (pop),
    .wr_data (push_data_reg),
    .rd_data (head_byte),
    .count   (fifo_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_ff @(posedge CLK_66 or negedge RST) begin
    if (!RST) state_reg <= IDLE;
    else      state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      IDLE:      if (enable && (fifo_count >= LEN_CNT)) state_next = SEND_SOF;
      SEND_SOF:  if (gap_last) state_next = SEND_SEQ;
      SEND_SEQ:  if (gap_last) state_next = SEND_LEN;
      SEND_LEN:  if (gap_last) state_next = SEND_DATA;
      SEND_DATA: if (gap_last && (idx_reg == IDX_LAST)) state_next = SEND_CSUM;
      SEND_CSUM: if (gap_last) state_next = IDLE;
      default:   state_next = IDLE;
    endcase
    if (flush) state_next = IDLE;
  end

  always_comb begin
    busy           = (state_reg != IDLE);
    start_transfer = busy && (gap_reg == '0) && !flush;
    cur_byte       = 8'h00;
    unique case (state_reg)
      SEND_SOF:  cur_byte = SOF_BYTE;
      SEND_SEQ:  cur_byte = seq_reg;
      SEND_LEN:  cur_byte = LEN_BYTE;
      SEND_DATA: cur_byte = head_byte;
      SEND_CSUM: cur_byte = csum_reg;
      default:   cur_byte = 8'h00;
    endcase
    pop              = start_transfer && (state_reg == SEND_DATA) && !fifo_empty;
    transfer_to_host = start_transfer ? cur_byte : tx_hold_reg;
  end

  always_ff @(posedge CLK_66 or negedge RST) begin
    if (!RST) begin
      gap_reg      <= '0;
      idx_reg      <= '0;
      seq_reg      <= '0;
      csum_reg     <= '0;
      tx_hold_reg  <= '0;
      overflow_reg <= 1'b0;
    end else begin
      if ((state_reg == IDLE) || gap_last || flush) gap_reg <= '0;
      else                                          gap_reg <= gap_reg + 1'b1;

      if ((state_reg != SEND_DATA) || flush) idx_reg <= '0;
      else if (gap_last)                     idx_reg <= idx_reg + 1'b1;

      if ((state_reg == SEND_CSUM) && gap_last && !flush) seq_reg <= seq_reg + 1'b1;

      // Checksum is seeded with seq+length while idle, payload added as popped
      if (state_reg == IDLE) csum_reg <= seq_reg + LEN_BYTE;
      else if (pop)          csum_reg <= csum_reg + head_byte;

      if (start_transfer) tx_hold_reg <= cur_byte;

      if (flush)                                overflow_reg <= 1'b0;
      else if (push_reg && fifo_full && !pop)   overflow_reg <= 1'b1;
    end
  end

  assign overflow = overflow_reg;

endmodule

// File: tb/tb_collector_tx_packetizer.sv
// Randomised directed bench for collector_tx_packetizer; expected packets
// come from a byte-queue model of what was strobed in.
`timescale 1ns/1ps
module tb_collector_tx_packetizer;

  logic       CLK_66 = 1'b0;
  logic       RST = 1'b0;
  logic       enable = 1'b0;
  logic       flush = 1'b0;
  logic       wr_strobe_async = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       start_transfer;
  logic [7:0] transfer_to_host;
  logic [4:0] fifo_count;
  logic       overflow;
  logic       busy;

  always #7.5 CLK_66 = ~CLK_66;

  collector_tx_packetizer dut (
    .CLK_66           (CLK_66),
    .RST              (RST),
    .enable           (enable),
    .flush            (flush),
    .wr_strobe_async  (wr_strobe_async),
    .wr_data          (wr_data),
    .start_transfer   (start_transfer),
    .transfer_to_host (transfer_to_host),
    .fifo_count       (fifo_count),
    .overflow         (overflow),
    .busy             (busy)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [7:0] pulse_q[$];
  int         pulse_t[$];
  logic [7:0] last_pulse = 8'h00;
  int         hold_err = 0;
  int         busy_err = 0;

  logic [7:0] mq[$];
  logic       movf = 1'b0;
  logic [7:0] mseq = 8'h00;
  logic [7:0] last_pkt[8];

  always @(posedge CLK_66) cyc <= cyc + 1;

  // Records every pulse and watches that the byte holds between pulses
  always @(negedge CLK_66) begin
    if (start_transfer === 1'b1) begin
      pulse_q.push_back(transfer_to_host);
      pulse_t.push_back(cyc);
      last_pulse <= transfer_to_host;
      if (busy !== 1'b1) busy_err <= busy_err + 1;
    end else if (busy === 1'b1 && transfer_to_host !== last_pulse) begin
      hold_err <= hold_err + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge CLK_66);
  endtask

  task automatic strobe(input logic [7:0] d, input int hi, input int lo);
    @(negedge CLK_66);
    wr_data = d;
    wr_strobe_async = 1'b1;
    tick(hi);
    wr_strobe_async = 1'b0;
    tick(lo);
    if (mq.size() < 16) mq.push_back(d);
    else movf = 1'b1;
  endtask

  task automatic strobe_rand(input logic [7:0] d);
    strobe(d, $urandom_range(1, 5), $urandom_range(3, 6));
  endtask

  task automatic wait_pulses(input int n, input int budget, input string tag);
    int k = 0;
    while (pulse_q.size() < n && k < budget) begin
      tick(1);
      k++;
    end
    if (pulse_q.size() < n) check({tag, "_timeout"}, pulse_q.size(), n);
  endtask

  task automatic clear_pulses();
    pulse_q.delete();
    pulse_t.delete();
  endtask

  task automatic check_packet(input string tag);
    logic [7:0] e[8];
    int sum;
    e[0] = 8'hA5;
    e[1] = mseq;
    e[2] = 8'd4;
    sum = int'(mseq) + 4;
    for (int i = 0; i < 4; i++) begin
      e[3+i] = mq.pop_front();
      sum += int'(e[3+i]);
    end
    e[7] = 8'(sum % 256);
    wait_pulses(8, 400, tag);
    for (int i = 0; i < 8; i++) begin
      if (i < pulse_q.size()) begin
        check($sformatf("%s_b%0d", tag, i), pulse_q[i], e[i]);
        last_pkt[i] = pulse_q[i];
      end
    end
    for (int i = 1; i < 8; i++) begin
      if (i < pulse_t.size())
        check($sformatf("%s_gap%0d", tag, i), pulse_t[i] - pulse_t[i-1], 8);
    end
    for (int i = 0; i < 8; i++) begin
      if (pulse_q.size() > 0) begin
        void'(pulse_q.pop_front());
        void'(pulse_t.pop_front());
      end
    end
    mseq = mseq + 8'd1;
  endtask

  task automatic do_reset();
    enable = 1'b0;
    RST = 1'b0;
    tick(3);
    RST = 1'b1;
    mq.delete();
    movf = 1'b0;
    mseq = 8'h00;
    clear_pulses();
    tick(2);
  endtask

  initial begin
    // Reset state
    tick(3);
    check("rst_start", start_transfer, 0);
    check("rst_byte", transfer_to_host, 0);
    check("rst_count", fifo_count, 0);
    check("rst_ovf", overflow, 0);
    check("rst_busy", busy, 0);
    RST = 1'b1;
    tick(2);

    // Basic packet with capture latency check
    enable = 1'b1;
    tick(1);
    wr_data = 8'h11;
    wr_strobe_async = 1'b1;
    tick(3);
    check("lat_before", fifo_count, 0);
    tick(1);
    check("lat_after", fifo_count, 1);
    wr_strobe_async = 1'b0;
    tick(4);
    mq.push_back(8'h11);
    strobe(8'h22, 2, 4);
    strobe(8'h33, 3, 3);
    strobe(8'h44, 1, 5);
    check_packet("pkt1");
    check("pkt1_csum", last_pkt[7], 8'hAE);
    tick(12);
    check("pkt1_count", fifo_count, 0);
    check("pkt1_busy", busy, 0);

    // Below-threshold bytes wait while disabled
    do_reset();
    for (int i = 0; i < 3; i++) strobe_rand(8'($urandom));
    tick(20);
    check("dis_pulses", pulse_q.size(), 0);
    check("dis_count", fifo_count, 3);
    strobe_rand(8'($urandom));
    enable = 1'b1;
    check_packet("pkt2");
    tick(12);
    check("pkt2_count", fifo_count, mq.size());

    // Overflow, enable dropping mid-packet, flush clears
    do_reset();
    for (int i = 0; i < 17; i++) strobe_rand(8'($urandom));
    check("ovf_count", fifo_count, mq.size());
    check("ovf_flag", overflow, movf);
    enable = 1'b1;
    wait_pulses(1, 50, "ovf_start");
    enable = 1'b0;
    check_packet("pkt3");
    tick(100);
    check("en_off_pulses", pulse_q.size(), 0);
    check("en_off_count", fifo_count, mq.size());
    check("en_off_busy", busy, 0);
    check("en_off_ovf", overflow, movf);
    flush = 1'b1;
    tick(1);
    flush = 1'b0;
    mq.delete();
    movf = 1'b0;
    check("flush_count", fifo_count, 0);
    check("flush_ovf", overflow, 0);

    // Flush coinciding with the push of a captured byte drops it
    tick(1);
    wr_data = 8'($urandom);
    wr_strobe_async = 1'b1;
    tick(3);
    flush = 1'b1;
    tick(1);
    flush = 1'b0;
    wr_strobe_async = 1'b0;
    tick(5);
    check("flush_vs_push", fifo_count, 0);

    // Flush mid-packet aborts without consuming a sequence number
    enable = 1'b1;
    for (int i = 0; i < 4; i++) strobe_rand(8'($urandom));
    wait_pulses(2, 100, "abort");
    tick(2);
    flush = 1'b1;
    tick(1);
    flush = 1'b0;
    if (pulse_q.size() >= 2) begin
      check("abort_sof", pulse_q[0], 8'hA5);
      check("abort_seq", pulse_q[1], mseq);
    end
    tick(100);
    check("abort_pulses", pulse_q.size(), 2);
    check("abort_busy", busy, 0);
    check("abort_count", fifo_count, 0);
    check("abort_ovf", overflow, 0);
    clear_pulses();
    mq.delete();
    for (int i = 0; i < 4; i++) strobe_rand(8'($urandom));
    check_packet("pkt_after_abort");

    // Sequence wrap over 257 zero-payload packets
    do_reset();
    enable = 1'b1;
    for (int k = 0; k < 257; k++) begin
      for (int i = 0; i < 4; i++) strobe(8'h00, $urandom_range(1, 3), 3);
      check_packet($sformatf("p%0d", k));
      if (k == 255) begin
        check("wrap_seq_ff", last_pkt[1], 8'hFF);
        check("wrap_csum_03", last_pkt[7], 8'h03);
      end
      if (k == 256) check("wrap_seq_00", last_pkt[1], 8'h00);
    end
    tick(20);

    // Long strobe pushes once
    enable = 1'b0;
    tick(1);
    wr_data = 8'h5C;
    wr_strobe_async = 1'b1;
    tick(100);
    wr_strobe_async = 1'b0;
    tick(6);
    mq.push_back(8'h5C);
    check("long_strobe", fifo_count, 1);

    // Asynchronous reset mid-packet
    enable = 1'b1;
    for (int i = 0; i < 3; i++) strobe_rand(8'($urandom));
    wait_pulses(3, 200, "rst_mid");
    @(posedge CLK_66);
    #2 RST = 1'b0;
    #1;
    check("arst_start", start_transfer, 0);
    check("arst_byte", transfer_to_host, 0);
    check("arst_count", fifo_count, 0);
    check("arst_ovf", overflow, 0);
    check("arst_busy", busy, 0);
    tick(2);
    enable = 1'b0;
    RST = 1'b1;
    mq.delete();
    mseq = 8'h00;
    clear_pulses();
    tick(20);
    check("post_rst_pulses", pulse_q.size(), 0);

    check("hold_stable", hold_err, 0);
    check("busy_at_pulse", busy_err, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
